// File: rtl/ram_sp_init_if.sv
// Access bundle for ram_sp_init: request, write data/mask, init request
// and the read/status responses.
interface ram_sp_init_if #(
    parameter int AW    = 11,
    parameter int WIDTH = 39
) ();
    logic             ME;
    logic             WE;
    logic [AW-1:0]    ADR;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] WEM;
    logic             INIT_REQ;
    logic [WIDTH-1:0] Q;
    logic             QV;
    logic             BUSY;
    logic             ERR;

    modport master (
        output ME, WE, ADR, D, WEM, INIT_REQ,
        input  Q, QV, BUSY, ERR
    );

    modport slave (
        input  ME, WE, ADR, D, WEM, INIT_REQ,
        output Q, QV, BUSY, ERR
    );
endinterface

// File: rtl/ram_sp_init.sv
// Single-port synchronous SRAM model with masked writes, 1/2-cycle reads,
// range checking and a hardware fill sequencer that owns the port while BUSY.
module ram_sp_init #(
    parameter int               DEPTH    = 2048,
    parameter int               WIDTH    = 39,
    parameter int               RD_LAT   = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter int               AW       = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RST_L,
    ram_sp_init_if.slave bus
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    cnt;
    logic [AW-1:0]    cnt_nx;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             busy;
    logic             accept;
    logic             in_range;
    logic             rd_acc;
    logic             wr_acc;
    logic             oor;
    logic [WIDTH-1:0] rd_data;

    logic             s1_v;
    logic             s1_e;
    logic [WIDTH-1:0] s1_d;

    assign busy     = (state == S_INIT);
    assign accept   = bus.ME & ~busy & ~bus.INIT_REQ;
    assign in_range = ({1'b0, bus.ADR} < DEPTH_W);
    assign rd_acc   = accept & ~bus.WE;
    assign wr_acc   = accept & bus.WE & in_range;
    assign oor      = accept & ~in_range;
    assign rd_data  = in_range ? mem[bus.ADR] : '0;

    assign bus.BUSY = busy;

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_INIT: begin
                if (bus.INIT_REQ) begin
                    cnt_nx = '0;
                end else if (cnt == LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + AW'(1);
                end
            end
            S_IDLE: begin
                if (bus.INIT_REQ) begin
                    state_nx = S_INIT;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_INIT;
                cnt_nx   = '0;
            end
        endcase
    end

    // Array contents are deliberately never reset; the fill sequencer
    // replaces them after every reset release.
    always_ff @(posedge CLK) begin
        if (busy) begin
            mem[cnt] <= INIT_VAL;
        end else if (wr_acc) begin
            mem[bus.ADR] <= (mem[bus.ADR] & ~bus.WEM) |
                            (bus.D & bus.WEM);
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            s1_v <= 1'b0;
            s1_e <= 1'b0;
            s1_d <= '0;
        end else begin
            s1_v <= rd_acc;
            s1_e <= oor;
            if (rd_acc) begin
                s1_d <= rd_data;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             s2_v;
            logic             s2_e;
            logic [WIDTH-1:0] s2_d;

            always_ff @(posedge CLK or negedge RST_L) begin
                if (!RST_L) begin
                    s2_v <= 1'b0;
                    s2_e <= 1'b0;
                    s2_d <= '0;
                end else begin
                    s2_v <= s1_v;
                    s2_e <= s1_e;
                    if (s1_v) begin
                        s2_d <= s1_d;
                    end
                end
            end

            assign bus.Q   = s2_d;
            assign bus.QV  = s2_v;
            assign bus.ERR = s2_e;
        end else begin : g_lat1
            assign bus.Q   = s1_d;
            assign bus.QV  = s1_v;
            assign bus.ERR = s1_e;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sp_init.sv
// Directed bench: a 16x8 RD_LAT=1 array and a 12x8 RD_LAT=2 array,
// both filled with 8'hA5, checked against hand-computed vectors.
module tb_ram_sp_init;

    logic CLK;
    logic RST_L;

    ram_sp_init_if #(.AW(4), .WIDTH(8)) ia ();
    ram_sp_init_if #(.AW(4), .WIDTH(8)) ib ();

    ram_sp_init #(
        .DEPTH(16), .WIDTH(8), .RD_LAT(1), .INIT_VAL(8'hA5)
    ) dut_a (
        .CLK(CLK), .RST_L(RST_L), .bus(ia)
    );

    ram_sp_init #(
        .DEPTH(12), .WIDTH(8), .RD_LAT(2), .INIT_VAL(8'hA5)
    ) dut_b (
        .CLK(CLK), .RST_L(RST_L), .bus(ib)
    );

    typedef struct {
        logic       me;
        logic       we;
        logic [3:0] adr;
        logic [7:0] d;
        logic [7:0] wem;
        logic [7:0] q;
        logic       qv;
    } vec_t;

    vec_t       tv[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] badr[16];
    logic [7:0] bexp[16];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic me, input logic we,
                                input logic [3:0] adr, input logic [7:0] d,
                                input logic [7:0] wem, input logic [7:0] q,
                                input logic qv);
        vec_t v;
        v.me = me; v.we = we; v.adr = adr; v.d = d;
        v.wem = wem; v.q = q; v.qv = qv;
        return v;
    endfunction

    task automatic drv_a(input logic me, input logic we, input logic [3:0] adr,
                         input logic [7:0] d, input logic [7:0] wem);
        ia.ME = me; ia.WE = we; ia.ADR = adr; ia.D = d; ia.WEM = wem;
    endtask

    task automatic drv_b(input logic me, input logic we, input logic [3:0] adr,
                         input logic [7:0] d, input logic [7:0] wem);
        ib.ME = me; ib.WE = we; ib.ADR = adr; ib.D = d; ib.WEM = wem;
    endtask

    task automatic rd_a(input logic [3:0] adr, input logic [7:0] exp,
                        input string nm);
        drv_a(1'b1, 1'b0, adr, 8'h00, 8'h00);
        tick();
        drv_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk({nm, "_q"}, ia.Q, exp);
        chk({nm, "_qv"}, ia.QV, 1);
    endtask

    // Init lengths counted in edges from reset release (or request).
    task automatic wait_init(output int fa, output int fb);
        fa = 0;
        fb = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!ia.BUSY && fa == 0) fa = i;
            if (!ib.BUSY && fb == 0) fb = i;
        end
    endtask

    // Back-to-back reads on the two-cycle array: data lands two edges later.
    task automatic burst_b(input int n, input string nm);
        for (int i = 0; i <= n + 1; i++) begin
            if (i < n) drv_b(1'b1, 1'b0, badr[i], 8'h00, 8'h00);
            else       drv_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
            tick();
            if (i >= 1 && i <= n) begin
                chk({nm, "_q"}, ib.Q, bexp[i-1]);
                chk({nm, "_qv"}, ib.QV, 1);
            end else begin
                chk({nm, "_qv_idle"}, ib.QV, 0);
            end
        end
        chk({nm, "_q_hold"}, ib.Q, bexp[n-1]);
    endtask

    initial begin
        int fa;
        int fb;
        int n;
        int bad_qv;

        RST_L = 1'b0;
        drv_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        drv_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        ia.INIT_REQ = 1'b0;
        ib.INIT_REQ = 1'b0;

        for (int i = 0; i < 16; i++) tv.push_back(mk(1, 0, 4'(i), 0, 0, 8'hA5, 1));
        tv.push_back(mk(1, 1, 4'd3, 8'hFF, 8'h0F, 8'hA5, 0));
        tv.push_back(mk(1, 0, 4'd3, 8'h00, 8'h00, 8'hAF, 1));
        tv.push_back(mk(1, 1, 4'd3, 8'h00, 8'h00, 8'hAF, 0));
        tv.push_back(mk(1, 0, 4'd3, 8'h00, 8'h00, 8'hAF, 1));
        tv.push_back(mk(1, 0, 4'd2, 8'h00, 8'h00, 8'hA5, 1));
        tv.push_back(mk(1, 1, 4'd4, 8'h5A, 8'hF0, 8'hA5, 0));
        tv.push_back(mk(1, 0, 4'd4, 8'h00, 8'h00, 8'h55, 1));
        tv.push_back(mk(1, 1, 4'd5, 8'h3C, 8'hFF, 8'h55, 0));
        tv.push_back(mk(0, 0, 4'd0, 8'h00, 8'h00, 8'h55, 0));
        tv.push_back(mk(1, 0, 4'd5, 8'h00, 8'h00, 8'h3C, 1));

        repeat (3) tick();
        chk("rst_q_a", ia.Q, 0);
        chk("rst_qv_a", ia.QV, 0);
        chk("rst_err_a", ia.ERR, 0);
        chk("rst_busy_a", ia.BUSY, 1);
        chk("rst_busy_b", ib.BUSY, 1);

        RST_L = 1'b1;
        wait_init(fa, fb);
        chk("init_len_a", fa, 16);
        chk("init_len_b", fb, 12);

        foreach (tv[k]) begin
            drv_a(tv[k].me, tv[k].we, tv[k].adr, tv[k].d, tv[k].wem);
            tick();
            chk($sformatf("vec%0d_q", k), ia.Q, tv[k].q);
            chk($sformatf("vec%0d_qv", k), ia.QV, tv[k].qv);
            chk($sformatf("vec%0d_err", k), ia.ERR, 0);
        end
        drv_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);

        // Read in flight, then INIT_REQ colliding with a new read.
        rd_a(4'd5, 8'h3C, "inflight_a");
        ia.INIT_REQ = 1'b1;
        drv_a(1'b1, 1'b0, 4'd5, 8'h00, 8'h00);
        tick();
        ia.INIT_REQ = 1'b0;
        chk("collide_qv_a", ia.QV, 0);
        chk("reinit_busy_a", ia.BUSY, 1);
        n = 0;
        bad_qv = 0;
        while (ia.BUSY && n < 40) begin
            n++;
            drv_a(1'b1, 1'b0, 4'd5, 8'h00, 8'h00);
            tick();
            if (ia.QV) bad_qv++;
        end
        drv_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk("reinit_len_a", n, 16);
        chk("busy_drop_qv_a", bad_qv, 0);
        rd_a(4'd5, 8'hA5, "after_reinit_a");

        // Reset in the middle of a fill.
        ia.INIT_REQ = 1'b1;
        tick();
        ia.INIT_REQ = 1'b0;
        repeat (6) tick();
        chk("midinit_busy_a", ia.BUSY, 1);
        RST_L = 1'b0;
        #1;
        chk("midrst_q_a", ia.Q, 0);
        chk("midrst_qv_a", ia.QV, 0);
        chk("midrst_err_a", ia.ERR, 0);
        chk("midrst_busy_a", ia.BUSY, 1);
        tick();
        tick();
        RST_L = 1'b1;
        wait_init(fa, fb);
        chk("reinit2_len_a", fa, 16);
        chk("reinit2_len_b", fb, 12);
        for (int i = 0; i < 16; i++) rd_a(4'(i), 8'hA5, $sformatf("fill_a%0d", i));

        for (int i = 0; i < 4; i++) begin
            drv_b(1'b1, 1'b1, 4'(i), 8'(i + 1), 8'hFF);
            tick();
        end
        drv_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            badr[i] = 4'(i);
            bexp[i] = 8'(i + 1);
        end
        burst_b(4, "pipe_b");

        drv_b(1'b1, 1'b0, 4'd13, 8'h00, 8'h00);
        tick();
        drv_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk("oor_rd_early_err", ib.ERR, 0);
        chk("oor_rd_early_qv", ib.QV, 0);
        tick();
        chk("oor_rd_q", ib.Q, 0);
        chk("oor_rd_qv", ib.QV, 1);
        chk("oor_rd_err", ib.ERR, 1);
        tick();
        chk("oor_rd_err_end", ib.ERR, 0);
        chk("oor_rd_qv_end", ib.QV, 0);

        drv_b(1'b1, 1'b1, 4'd14, 8'hFF, 8'hFF);
        tick();
        drv_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk("oor_wr_early_err", ib.ERR, 0);
        tick();
        chk("oor_wr_err", ib.ERR, 1);
        chk("oor_wr_qv", ib.QV, 0);
        tick();
        chk("oor_wr_err_end", ib.ERR, 0);

        for (int i = 0; i < 12; i++) begin
            badr[i] = 4'(i);
            bexp[i] = (i < 4) ? 8'(i + 1) : 8'hA5;
        end
        burst_b(12, "all_b");

        // Two-cycle read still completes after INIT_REQ lands behind it.
        drv_b(1'b1, 1'b0, 4'd1, 8'h00, 8'h00);
        tick();
        drv_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        ib.INIT_REQ = 1'b1;
        tick();
        ib.INIT_REQ = 1'b0;
        chk("inflight_b_q", ib.Q, 2);
        chk("inflight_b_qv", ib.QV, 1);
        chk("inflight_b_busy", ib.BUSY, 1);
        n = 0;
        while (ib.BUSY && n < 40) begin
            n++;
            tick();
            if (n == 1) chk("inflight_b_qv_end", ib.QV, 0);
        end
        chk("reinit_len_b", n, 12);
        badr[0] = 4'd1;
        bexp[0] = 8'hA5;
        burst_b(1, "after_reinit_b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
